// File: rtl/pipe_pkg.sv
// Shared pipeline constants: MDU latencies, tracker state encoding and the
// hazard-control output bundle used by the ID/EX hazard logic.
package pipe_pkg;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MDU_WAIT = 1'b1;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
    } hazard_ctl_t;

    localparam hazard_ctl_t CTL_RUN    = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
    localparam hazard_ctl_t CTL_STALL  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
    localparam hazard_ctl_t CTL_SQUASH = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};

    // Bits needed to hold the largest reload value (latency - 1).
    function automatic int lat_cnt_w(input int mul_lat, input int div_lat);
        int max_lat;
        max_lat = (mul_lat > div_lat) ? mul_lat : div_lat;
        return (max_lat > 2) ? $clog2(max_lat) : 1;
    endfunction

endpackage

// File: rtl/hazard_mdu_tracker.sv
// Tracks HI/LO occupancy of the multi-cycle multiply/divide unit:
// RUN/MDU_WAIT state machine with a reload-and-count-down latency counter.
module hazard_mdu_tracker
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic issue_div,
    output logic mdu_busy
);

    localparam int CW = lat_cnt_w(MUL_LAT, DIV_LAT);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (issue) begin
                    state_d = ST_MDU_WAIT;
                    cnt_d   = issue_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            ST_MDU_WAIT: begin
                // Branch squash is deliberately ignored here: the op already left ID.
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decode of registered state: high for exactly LAT cycles after the issue cycle.
    assign mdu_busy = (state_q == ST_MDU_WAIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO stalls, taken-branch squash,
// and a saturating count of cycles in which the PC was held.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_mfhilo,
    input  logic             id_mdu_start,
    input  logic             id_mdu_div,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regw,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [4:0]  src_reg [2];
    logic [1:0]  src_used;
    logic [1:0]  src_match;
    logic        load_use;
    logic        hilo_hazard;
    logic        mdu_issue;
    hazard_ctl_t ctl;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign src_reg[0] = id_rs;
    assign src_reg[1] = id_rt;
    assign src_used   = {id_uses_rt, 1'b1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_used[gi] & (src_reg[gi] == ex_rd);
        end
    endgenerate

    // Loads into $zero never produce a value worth waiting for.
    assign load_use    = ex_memread & ex_regw & (ex_rd != REG_ZERO) & (|src_match);
    assign hilo_hazard = mdu_busy & (id_mfhilo | id_mdu_start);

    always_comb begin
        ctl = CTL_RUN;
        if (rst) begin
            ctl = CTL_RUN;
        end else if (ex_branch_taken) begin
            ctl = CTL_SQUASH;
        end else if (load_use | hilo_hazard) begin
            ctl = CTL_STALL;
        end
    end

    assign pc_we       = ctl.pc_we;
    assign ifid_we     = ctl.ifid_we;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_bubble = ctl.idex_bubble;

    // The MDU op only starts in the cycle it really advances out of ID.
    assign mdu_issue = id_mdu_start & ~ex_branch_taken & ~load_use & ~hilo_hazard;

    hazard_mdu_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_tracker (
        .clk       (clk),
        .rst       (rst),
        .issue     (mdu_issue),
        .issue_div (id_mdu_div),
        .mdu_busy  (mdu_busy)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctl.pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
